// File: rtl/am2950_fifo_core.sv
// One direction of the bus port: DEPTH-entry FIFO with active-low strobes and status flags.
// Optional sticky overrun flag is built only when AM2950_FIFO_PORT_OVR_EN is defined.
module am2950_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] din,
  input  logic             push_,
  input  logic             pop_,
  output logic [WIDTH-1:0] head,
  output logic             nempty,
  output logic             full
`ifdef AM2950_FIFO_PORT_OVR_EN
  ,
  output logic             ovr
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop  = !pop_ && (count_reg != '0);
  assign do_push = !push_ && ((count_reg != FULL_CNT) || do_pop);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop)
        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef AM2950_FIFO_PORT_OVR_EN
  logic ovr_reg;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      ovr_reg <= 1'b0;
    else if (!push_ && !do_push)
      ovr_reg <= 1'b1;
  end
  assign ovr = ovr_reg;
`endif

  assign head   = mem_reg[rd_ptr_reg];
  assign nempty = (count_reg != '0);
  assign full   = (count_reg == FULL_CNT);
endmodule

// File: rtl/am2950_fifo_port.sv
// Bidirectional buffered bus port: one FIFO per direction plus tristate bus drivers.
// Define AM2950_FIFO_PORT_OVR_EN to add the sticky ovrab/ovrba overrun flags.
module am2950_fifo_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             ldab_,
  input  logic             ldba_,
  input  logic             rdab_,
  input  logic             rdba_,
  input  logic             oeb_,
  input  logic             oea_,
  output logic             fab,
  output logic             fba,
  output logic             fullab,
  output logic             fullba
`ifdef AM2950_FIFO_PORT_OVR_EN
  ,
  output logic             ovrab,
  output logic             ovrba
`endif
);
  logic [WIDTH-1:0] head_ab, head_ba;

  am2950_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ab (
    .clk    (clk),
    .rst_   (rst_),
    .din    (a),
    .push_  (ldab_),
    .pop_   (rdab_),
    .head   (head_ab),
    .nempty (fab),
    .full   (fullab)
`ifdef AM2950_FIFO_PORT_OVR_EN
    ,
    .ovr    (ovrab)
`endif
  );

  am2950_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ba (
    .clk    (clk),
    .rst_   (rst_),
    .din    (b),
    .push_  (ldba_),
    .pop_   (rdba_),
    .head   (head_ba),
    .nempty (fba),
    .full   (fullba)
`ifdef AM2950_FIFO_PORT_OVR_EN
    ,
    .ovr    (ovrba)
`endif
  );

  // Enables are purely combinational; a pushing while oea_ is low loads our own head.
  assign b = oeb_ ? {WIDTH{1'bz}} : head_ab;
  assign a = oea_ ? {WIDTH{1'bz}} : head_ba;
endmodule

// File: tb/tb_am2950_fifo_port.sv
// Directed bench for am2950_fifo_port (WIDTH=8, DEPTH=4) with per-direction scoreboard queues.
module tb_am2950_fifo_port;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_;
  logic ldab_, ldba_, rdab_, rdba_, oeb_, oea_;
  logic fab, fba, fullab, fullba;
`ifdef AM2950_FIFO_PORT_OVR_EN
  logic ovrab, ovrba;
`endif
  wire  [W-1:0] a, b;
  logic [W-1:0] a_drv, b_drv;
  logic         a_en, b_en;

  assign a = a_en ? a_drv : {W{1'bz}};
  assign b = b_en ? b_drv : {W{1'bz}};

  always #5 clk = ~clk;

  am2950_fifo_port #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .a      (a),
    .b      (b),
    .ldab_  (ldab_),
    .ldba_  (ldba_),
    .rdab_  (rdab_),
    .rdba_  (rdba_),
    .oeb_   (oeb_),
    .oea_   (oea_),
    .fab    (fab),
    .fba    (fba),
    .fullab (fullab),
    .fullba (fullba)
`ifdef AM2950_FIFO_PORT_OVR_EN
    ,
    .ovrab  (ovrab),
    .ovrba  (ovrba)
`endif
  );

  int checks = 0;
  int passes = 0;
  logic [W-1:0] q_ab[$];
  logic [W-1:0] q_ba[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
      $display("check %s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ab(input logic [W-1:0] v);
    a_drv = v; a_en = 1'b1; ldab_ = 1'b0;
    if (q_ab.size() < D) q_ab.push_back(v);
    tick();
    ldab_ = 1'b1; a_en = 1'b0;
  endtask

  task automatic pop_ab(input string tag);
    logic [W-1:0] exp;
    oeb_ = 1'b0;
    #1;
    exp = q_ab.pop_front();
    chk(tag, b, exp);
    rdab_ = 1'b0;
    tick();
    rdab_ = 1'b1;
  endtask

  // Model of simultaneous push/pop: pop only when non-empty; pop frees a full slot.
  task automatic pushpop_ab(input logic [W-1:0] v);
    a_drv = v; a_en = 1'b1; ldab_ = 1'b0; rdab_ = 1'b0;
    if (q_ab.size() != 0) void'(q_ab.pop_front());
    if (q_ab.size() < D) q_ab.push_back(v);
    tick();
    ldab_ = 1'b1; rdab_ = 1'b1; a_en = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0;
    ldab_ = 1'b1; ldba_ = 1'b1; rdab_ = 1'b1; rdba_ = 1'b1;
    oeb_ = 1'b1; oea_ = 1'b1;
    a_en = 1'b1; a_drv = 8'h3C; b_en = 1'b1; b_drv = 8'hC3;
    #2;
    // DUT released buses: bench values read back unaltered
    chk("rst_a_released", a, 8'h3C);
    chk("rst_b_released", b, 8'hC3);
    chk("rst_fab", fab, 1'b0);
    chk("rst_fba", fba, 1'b0);
    chk("rst_fullab", fullab, 1'b0);
    chk("rst_fullba", fullba, 1'b0);
    b_en = 1'b0; a_en = 1'b0;
    oeb_ = 1'b0;
    #1;
    chk("rst_b_drive0", b, 8'h00);
    oeb_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b1;

    push_ab(8'h11);
    chk("p11_fab", fab, 1'b1);
    chk("p11_fullab", fullab, 1'b0);
    pop_ab("p11_head");
    chk("p11_empty", fab, 1'b0);

    oeb_ = 1'b1;
    push_ab(8'hA1); push_ab(8'hA2); push_ab(8'hA3); push_ab(8'hA4);
    chk("fill_fullab", fullab, 1'b1);
    push_ab(8'hFF);
    chk("ovrpush_fullab", fullab, 1'b1);
`ifdef AM2950_FIFO_PORT_OVR_EN
    chk("ovrab_set", ovrab, 1'b1);
    chk("ovrba_clear", ovrba, 1'b0);
`endif
    for (int i = 0; i < D; i++) pop_ab($sformatf("drain1_%0d", i));
    chk("drain1_empty", fab, 1'b0);
`ifdef AM2950_FIFO_PORT_OVR_EN
    chk("ovrab_sticky", ovrab, 1'b1);
`endif

    oeb_ = 1'b1;
    push_ab(8'hA1); push_ab(8'hA2); push_ab(8'hA3); push_ab(8'hA4);
    pushpop_ab(8'h55);
    chk("fullpp_fullab", fullab, 1'b1);
    chk("fullpp_fab", fab, 1'b1);
    for (int i = 0; i < D; i++) pop_ab($sformatf("drain2_%0d", i));
    chk("drain2_empty", fab, 1'b0);

    oeb_ = 1'b1;
    pushpop_ab(8'h3C);
    chk("emptypp_fab", fab, 1'b1);
    chk("emptypp_fullab", fullab, 1'b0);
    oeb_ = 1'b0;
    #1;
    chk("emptypp_head", b, q_ab[0]);
    oeb_ = 1'b1;

    b_drv = 8'h77; b_en = 1'b1; ldba_ = 1'b0;
    q_ba.push_back(8'h77);
    tick();
    ldba_ = 1'b1; b_en = 1'b0;
    chk("ba_fba", fba, 1'b1);
    oea_ = 1'b0;
    #1;
    chk("ba_a_head", a, q_ba[0]);
    chk("ba_ab_fab", fab, 1'b1);
    oeb_ = 1'b0;
    #1;
    chk("ba_ab_head", b, q_ab[0]);
    oeb_ = 1'b1;

    // AB loads the value the block itself drives onto a
    ldab_ = 1'b0;
    q_ab.push_back(q_ba[0]);
    tick();
    ldab_ = 1'b1;
    oea_ = 1'b1;
    push_ab(8'h99);
    pop_ab("selfload_0");
    pop_ab("selfload_1");
    oeb_ = 1'b1;
    push_ab(8'h3C);
    chk("pre_rst_fab", fab, 1'b1);

    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("midrst_fab", fab, 1'b0);
    chk("midrst_fba", fba, 1'b0);
    chk("midrst_fullab", fullab, 1'b0);
`ifdef AM2950_FIFO_PORT_OVR_EN
    chk("midrst_ovrab", ovrab, 1'b0);
`endif
    oeb_ = 1'b0;
    #1;
    chk("midrst_b0", b, 8'h00);
    oeb_ = 1'b1;
    #1;
    rst_ = 1'b1;
    q_ab.delete();
    q_ba.delete();
    push_ab(8'h5E);
    chk("postrst_fab", fab, 1'b1);
    pop_ab("postrst_head");
    chk("postrst_empty", fab, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
